accumulator_delta_decoder: RTL and testbench
============================================

Name: accumulator_delta_decoder

Overview:
- Receiving end of the accumulator's output stream. Takes successive running-sum samples (sum plus carry-out) and recovers the per-cycle increment that produced each one (addend plus carry-in).
- Sits downstream of the accumulator, behind a valid/ready handshake, feeding a checker or consumer.
- Flags sample pairs that no legal increment could have produced.

Parameters:
WIDTH, 4, bit width of the sum sample; the increment output is WIDTH+1 bits.

Ports:
PHI  input  1  clock; all state updates on the rising edge
RST  input  1  asynchronous, active-low reset (0 = reset asserted)
IN_VALID  input  1  S/CO/SYNC carry a valid sample
IN_READY  output  1  decoder can accept a sample this cycle
S  input  WIDTH  running-sum sample (accumulator SOUT)
CO  input  1  carry-out that accompanied S (accumulator COUT)
SYNC  input  1  restart: the sample, or the next accepted one, becomes the new reference
OUT_VALID  output  1  D/ERR hold a decoded increment
OUT_READY  input  1  consumer takes D this cycle
D  output  WIDTH+1  decoded increment, range 0..2^WIDTH
ERR  output  1  decoded pair was illegal; qualified by OUT_VALID
PRIMED  output  1  reference sample held (state PRIMED)

Behaviour:
- Reset (RST=0, asynchronous):
  - state EMPTY, reference register REF=0.
  - OUT_VALID=0, D=0, ERR=0, PRIMED=0.
  - Outputs are registered, so these values appear immediately when reset asserts.
- Accept and handshake:
  - Accept = IN_VALID & IN_READY.
  - IN_READY = !OUT_VALID | OUT_READY; it is combinational from OUT_READY.
  - IN_READY is 0 while RST=0.
- States: EMPTY, PRIMED.
- Accept in EMPTY, or any accept with SYNC=1:
  - REF<=S; state->PRIMED.
  - No output is produced. CO on this sample is ignored.
  - OUT_VALID is updated only by the pop rule (it does not rise).
- Accept in PRIMED with SYNC=0:
  - Compute R = {CO,S} - {0,REF} in WIDTH+2-bit signed arithmetic.
  - Legal range is 0 <= R <= 2^WIDTH (max addend 2^WIDTH-1 plus carry-in 1).
  - Legal: D<=R[WIDTH:0], ERR<=0.
  - Illegal (R<0, or R>2^WIDTH): D<=R[WIDTH:0] (wrapped), ERR<=1.
  - REF<=S; OUT_VALID<=1 on the next edge.
  - Latency: 1 cycle from accept to OUT_VALID.
- Pop:
  - OUT_VALID & OUT_READY with no new decode in the same cycle -> OUT_VALID<=0.
  - Pop and decode in the same cycle -> OUT_VALID stays 1 and D/ERR take the new values. Full throughput, 1 sample/cycle.
- Stall: while OUT_VALID & !OUT_READY, D and ERR hold stable and IN_READY=0.
- SYNC without an accept:
  - state->EMPTY, PRIMED<=0.
  - A pending output stays valid and is not lost.
- D and ERR are don't-care whenever OUT_VALID=0. The bench checks them only when OUT_VALID=1.
- Reset mid-operation: a pending output is dropped. The first accepted sample after reset only primes REF.
- Wrap-around:
  - REF=15, S=2, CO=1 -> R=3, legal.
  - REF=2, S=15, CO=0 -> R=13, legal.
  - CO=1 with S>=REF -> R>2^WIDTH, ERR (except S=REF, which gives R=16, legal).

Test Plan:
1. Reset, then accept S=3,CO=0 -> no output, PRIMED=1; then S=8,CO=0 -> next cycle OUT_VALID=1, D=5, ERR=0.
2. Wrap: REF=14, accept S=1,CO=1 -> D=3, ERR=0; REF=5, accept S=5,CO=1 -> D=16, ERR=0.
3. Illegal pairs: REF=9, accept S=4,CO=0 -> ERR=1, D=27 (R=-5 wrapped to 5 bits); REF=4, accept S=9,CO=1 -> ERR=1, D=21.
4. Backpressure: OUT_READY=0 for 3 cycles with OUT_VALID=1 -> IN_READY=0, D stable; OUT_READY=1 with IN_VALID=1 -> back-to-back decodes, one per cycle, no loss or duplication.
5. SYNC: accept S=7,SYNC=1 while PRIMED with REF=2 -> no output, REF=7; then S=10 -> D=3. SYNC alone -> PRIMED=0, pending D still popped.
6. Drive the real accumulator with random A/CIN into this block (S=SOUT, CO=COUT) -> every D equals A+CIN of the matching cycle, ERR never set; async RST=0 mid-stream -> OUT_VALID=0 immediately, first post-reset sample only primes.

Source files
------------

// File: rtl/accumulator_delta_decoder_if.sv
// Sample-in / increment-out handshake bundle for the accumulator delta decoder.
interface accumulator_delta_decoder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] S;
  logic             CO;
  logic             SYNC;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH:0]   D;
  logic             ERR;
  logic             PRIMED;

  // Upstream producer / downstream consumer side
  modport master (
    output IN_VALID, S, CO, SYNC, OUT_READY,
    input  IN_READY, OUT_VALID, D, ERR, PRIMED
  );

  // Decoder side
  modport slave (
    input  IN_VALID, S, CO, SYNC, OUT_READY,
    output IN_READY, OUT_VALID, D, ERR, PRIMED
  );
endinterface

// File: rtl/accumulator_delta_decoder.sv
// Recovers the per-cycle increment (addend + carry-in) from successive
// accumulator {carry-out, sum} samples and flags pairs no legal increment fits.
module accumulator_delta_decoder #(
  parameter int unsigned WIDTH = 4
) (
  input logic                         PHI,
  input logic                         RST,
  accumulator_delta_decoder_if.slave  bus
);

  localparam int unsigned RW = WIDTH + 2;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_PRIMED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   dout_q, dout_d;
  logic             err_q, err_d;

  logic             in_ready_c;
  logic             accept_c;
  logic             decode_c;
  logic [RW-1:0]    diff_c;
  logic             illegal_c;

  // Ready whenever the output slot is free or being drained; forced low in reset
  assign in_ready_c = RST & (~out_valid_q | bus.OUT_READY);
  assign accept_c   = bus.IN_VALID & in_ready_c;
  assign decode_c   = accept_c & ~bus.SYNC & (state_q == ST_PRIMED);

  // Signed difference; range is -(2^W-1)..(2^(W+1)-1), so W+2 bits never overflow
  assign diff_c    = {1'b0, bus.CO, bus.S} - {2'b00, ref_q};
  // Negative, or above 2^W (bit W set with any lower bit set)
  assign illegal_c = diff_c[RW-1] | (diff_c[WIDTH] & (|diff_c[WIDTH-1:0]));

  // Next-state, reference and output-slot update
  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    out_valid_d = out_valid_q & ~bus.OUT_READY;
    dout_d      = dout_q;
    err_d       = err_q;

    if (accept_c) begin
      ref_d   = bus.S;
      state_d = ST_PRIMED;
      if (decode_c) begin
        out_valid_d = 1'b1;
        dout_d      = diff_c[WIDTH:0];
        err_d       = illegal_c;
      end
    end else if (bus.SYNC) begin
      state_d = ST_EMPTY;
    end
  end

  // State and output registers
  always_ff @(posedge PHI or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_EMPTY;
      ref_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      err_q       <= err_d;
    end
  end

  assign bus.IN_READY  = in_ready_c;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.D         = dout_q;
  assign bus.ERR       = err_q;
  assign bus.PRIMED    = (state_q == ST_PRIMED);

endmodule

// File: tb/tb_accumulator_delta_decoder.sv
// Bench for accumulator_delta_decoder: arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed expected values.
module tb_accumulator_delta_decoder;

  localparam int unsigned WIDTH = 4;
  localparam int          SPAN  = 1 << WIDTH;          // 16
  localparam int          MASK  = (1 << (WIDTH + 1)) - 1; // 31

  logic PHI = 1'b0;
  logic RST = 1'b0;
  always #5 PHI = ~PHI;

  accumulator_delta_decoder_if #(.WIDTH(WIDTH)) bus ();
  accumulator_delta_decoder #(.WIDTH(WIDTH)) dut (.PHI(PHI), .RST(RST), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: reference sample, primed flag, one output slot
  int m_ref;
  bit m_primed;
  bit m_ov;
  int m_d;
  bit m_err;

  always @(posedge PHI or negedge RST) begin
    bit rdy;
    bit acc;
    int r;
    if (!RST) begin
      m_ref = 0; m_primed = 0; m_ov = 0; m_d = 0; m_err = 0;
    end else begin
      rdy = !m_ov || bus.OUT_READY;
      acc = bus.IN_VALID && rdy;
      if (acc && (bus.SYNC || !m_primed)) begin
        m_ref    = int'(bus.S);
        m_primed = 1;
        m_ov     = m_ov && !bus.OUT_READY;
      end else if (acc) begin
        r     = (int'(bus.CO) * SPAN + int'(bus.S)) - m_ref;
        m_d   = r & MASK;
        m_err = (r < 0) || (r > SPAN);
        m_ref = int'(bus.S);
        m_ov  = 1;
      end else begin
        if (bus.SYNC) m_primed = 0;
        m_ov = m_ov && !bus.OUT_READY;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge PHI) begin
    chk("model_out_valid", int'(bus.OUT_VALID), int'(m_ov));
    chk("model_primed", int'(bus.PRIMED), int'(m_primed));
    chk("model_in_ready", int'(bus.IN_READY), int'(RST && (!m_ov || bus.OUT_READY)));
    if (m_ov) begin
      chk("model_d", int'(bus.D), m_d);
      chk("model_err", int'(bus.ERR), int'(m_err));
    end
  end

  // Drive one cycle of inputs; returns 2 time units after the consuming edge
  task automatic cyc(input bit iv, input int s, input bit co, input bit sync, input bit ordy);
    bus.IN_VALID  = iv;
    bus.S         = WIDTH'(s);
    bus.CO        = co;
    bus.SYNC      = sync;
    bus.OUT_READY = ordy;
    @(posedge PHI);
    #2;
  endtask

  // Hand-computed expectation on the output slot
  task automatic lit(input string name, input bit ov, input int d, input bit err);
    chk({name, "_valid"}, int'(bus.OUT_VALID), int'(ov));
    if (ov) begin
      chk({name, "_d"}, int'(bus.D), d);
      chk({name, "_err"}, int'(bus.ERR), int'(err));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int acc_sum;
    int a;
    int cin;
    int tot;
    bit primed_local;

    bus.IN_VALID = 0; bus.S = '0; bus.CO = 0; bus.SYNC = 0; bus.OUT_READY = 0;

    // 1. reset values, then prime and first decode
    #3;
    chk("rst_out_valid", int'(bus.OUT_VALID), 0);
    chk("rst_primed", int'(bus.PRIMED), 0);
    chk("rst_in_ready", int'(bus.IN_READY), 0);
    repeat (2) @(posedge PHI);
    #2;
    RST = 1'b1;
    cyc(1, 3, 0, 0, 1);
    lit("prime3", 0, 0, 0);
    chk("prime3_primed", int'(bus.PRIMED), 1);
    cyc(1, 8, 0, 0, 1);
    lit("dec_8_3", 1, 5, 0);

    // 2. wrap-around, including the 2^W upper bound
    cyc(1, 14, 0, 1, 1);
    lit("sync14", 0, 0, 0);
    cyc(1, 1, 1, 0, 1);
    lit("wrap_14_1c", 1, 3, 0);
    cyc(1, 5, 0, 1, 1);
    cyc(1, 5, 1, 0, 1);
    lit("max_5_5c", 1, 16, 0);

    // 3. illegal pairs
    cyc(1, 9, 0, 1, 1);
    cyc(1, 4, 0, 0, 1);
    lit("neg_9_4", 1, 27, 1);
    cyc(1, 4, 0, 1, 1);
    cyc(1, 9, 1, 0, 1);
    lit("over_4_9c", 1, 21, 1);

    // 4. backpressure then back-to-back decodes
    for (int i = 0; i < 3; i++) begin
      cyc(1, 12, 0, 0, 0);
      lit("stall", 1, 21, 1);
      chk("stall_in_ready", int'(bus.IN_READY), 0);
    end
    cyc(1, 12, 0, 0, 1);
    lit("b2b_0", 1, 3, 0);
    cyc(1, 13, 0, 0, 1);
    lit("b2b_1", 1, 1, 0);
    cyc(1, 15, 0, 0, 1);
    lit("b2b_2", 1, 2, 0);
    cyc(0, 0, 0, 0, 1);
    lit("drain", 0, 0, 0);

    // 5. SYNC with and without an accept
    cyc(1, 2, 0, 0, 1);
    lit("neg_15_2", 1, 19, 1);
    cyc(1, 7, 0, 1, 1);
    lit("resync7", 0, 0, 0);
    chk("resync7_primed", int'(bus.PRIMED), 1);
    cyc(1, 10, 0, 0, 1);
    lit("dec_10_7", 1, 3, 0);
    cyc(0, 0, 0, 1, 0);
    lit("sync_alone", 1, 3, 0);
    chk("sync_alone_primed", int'(bus.PRIMED), 0);
    cyc(0, 0, 0, 0, 1);
    lit("sync_pop", 0, 0, 0);
    cyc(1, 4, 0, 0, 1);
    lit("reprime4", 0, 0, 0);
    chk("reprime4_primed", int'(bus.PRIMED), 1);

    // 6. driven by an accumulator, with a reset in mid-stream
    acc_sum = 6;
    cyc(1, acc_sum, 0, 1, 1);
    primed_local = 1;
    for (int i = 0; i < 40; i++) begin
      a   = int'($urandom_range(0, SPAN - 1));
      cin = int'($urandom_range(0, 1));
      tot = acc_sum + a + cin;
      acc_sum = tot % SPAN;
      cyc(1, acc_sum, tot >= SPAN, 0, 1);
      if (primed_local) begin
        lit("acc_stream", 1, a + cin, 0);
      end else begin
        lit("acc_first_after_rst", 0, 0, 0);
        chk("acc_first_primed", int'(bus.PRIMED), 1);
        primed_local = 1;
      end
      if (i == 20) begin
        RST = 1'b0;
        #1;
        chk("midrst_out_valid", int'(bus.OUT_VALID), 0);
        chk("midrst_primed", int'(bus.PRIMED), 0);
        chk("midrst_in_ready", int'(bus.IN_READY), 0);
        @(posedge PHI);
        #2;
        RST = 1'b1;
        primed_local = 0;
      end
    end

    cyc(0, 0, 0, 0, 1);
    @(negedge PHI);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
